// File: rtl/aes_128_feeder.sv
// Feeder and result tracker for the pipelined aes_128 core: packs 32-bit words into
// 128-bit blocks, issues them with the shadowed key, and tags each one through the core latency.
module aes_128_feeder #(
  parameter int LATENCY = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic [31:0]  din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         abort,
  output logic [127:0] state,
  output logic [127:0] key,
  input  logic [127:0] core_out,
  output logic [127:0] dout,
  output logic         dout_valid,
  output logic [4:0]   inflight
);

  logic [1:0]       r_wc;
  logic [95:0]      r_partial;
  logic [127:0]     r_key_shadow;
  logic [127:0]     r_state;
  logic [127:0]     r_key;
  logic             r_issue;
  logic [LATENCY:0] r_tag;
  logic [127:0]     r_dout;
  logic             r_dout_valid;
  logic [4:0]       r_inflight;

  logic             w_accept;
  logic             w_issue;

  assign din_ready = ~rst;
  assign w_accept  = din_valid & din_ready & ~abort;
  assign w_issue   = w_accept & (r_wc == 2'd3);

  assign state      = r_state;
  assign key        = r_key;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign inflight   = r_inflight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wc         <= 2'd0;
      r_partial    <= '0;
      r_state      <= '0;
      r_key        <= '0;
      r_key_shadow <= '0;
      r_issue      <= 1'b0;
    end else begin
      r_issue <= w_issue;
      if (key_load) r_key_shadow <= key_in;
      if (abort) begin
        r_wc      <= 2'd0;
        r_partial <= '0;
      end else if (w_accept) begin
        r_wc <= 2'(r_wc + 2'd1);
        case (r_wc)
          2'd0: r_partial[95:64] <= din;
          2'd1: r_partial[63:32] <= din;
          2'd2: r_partial[31:0]  <= din;
          default: begin
            // shadow read here is the pre-load value when key_load coincides
            r_state <= {r_partial, din};
            r_key   <= r_key_shadow;
          end
        endcase
      end
    end
  end

  // r_issue marks the edge the core samples state/key, so stage 0 lines up with that edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_tag        <= {r_tag[LATENCY-1:0], r_issue};
      r_dout_valid <= r_tag[LATENCY];
      if (r_tag[LATENCY]) r_dout <= core_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 5'd0;
    end else begin
      case ({w_issue, r_dout_valid})
        2'b10: if (r_inflight != 5'd31) r_inflight <= r_inflight + 5'd1;
        2'b01: if (r_inflight != 5'd0)  r_inflight <= r_inflight - 5'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_feeder.sv
// Bench for aes_128_feeder: behavioural AES-128 core with fixed latency, directed vectors
// covering the reference vector, streaming, key race, abort, reset mid-flight and gapped input.
module tb_aes_128_feeder;

  localparam int LAT = 21;
  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT2  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CT11 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_load;
  logic [31:0]  din;
  logic         din_valid;
  logic         din_ready;
  logic         abort;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] core_out;
  logic [127:0] dout;
  logic         dout_valid;
  logic [4:0]   inflight;

  aes_128_feeder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .din(din), .din_valid(din_valid), .din_ready(din_ready), .abort(abort),
    .state(state), .key(key), .core_out(core_out),
    .dout(dout), .dout_valid(dout_valid), .inflight(inflight)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_edge = 0;
  int peak = 0;
  logic [127:0] q_data[$];
  int           q_edge[$];
  logic [7:0]   sbox[256];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && dout_valid) begin
      q_data.push_back(dout);
      q_edge.push_back(cyc);
    end
    if (int'(inflight) > peak) peak = int'(inflight);
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  initial begin : sbox_gen
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  end

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w[44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   st[16];
    logic [7:0]   t[16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox[st[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*c] = st[rr+4*((c+rr)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // core model: samples state/key every edge, result appears LAT edges later, never reset
  logic [127:0] core_pipe[LAT+1];
  always @(posedge clk) begin
    for (int i = LAT; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
    core_pipe[0] <= aes_enc(state, key);
  end
  assign core_out = core_pipe[LAT];

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    din_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    din = w;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    last_edge = cyc;
    din_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] pt, input int gap);
    for (int i = 0; i < 4; i++) send_word(pt[127-32*i -: 32], gap);
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in = k;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k;
    k = 0;
    while (q_data.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic clear_q();
    q_data.delete();
    q_edge.delete();
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin : main
    logic [127:0] pt;
    logic [127:0] exp_d[8];
    int           iss[8];
    int           gaps[4];
    rst = 1'b1; din = '0; din_valid = 1'b0; abort = 1'b0; key_in = '0; key_load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", din_ready, 0);
    check_val("rst_state", state, 0);
    check_val("rst_key", key, 0);
    check_val("rst_dout", dout, 0);
    check_val("rst_dvalid", dout_valid, 0);
    check_val("rst_inflight", inflight, 0);
    rst = 1'b0;
    #1;
    check_val("ready_up", din_ready, 1);

    // reference vector
    load_key(K1);
    clear_q();
    send_block(PT1, 0);
    iss[0] = last_edge;
    check_val("v_state", state, PT1);
    check_val("v_key", key, K1);
    check_val("v_infl1", inflight, 1);
    wait_strobes(1, 60);
    check_val("v_count", q_data.size(), 1);
    if (q_data.size() > 0) begin
      check_val("v_data", q_data[0], CT11);
      check_val("v_lat", q_edge[0], iss[0] + 23);
    end
    check_val("v_infl0", inflight, 0);

    // streaming, alternating plaintexts
    clear_q();
    peak = 0;
    for (int b = 0; b < 8; b++) begin
      pt = (b % 2 == 1) ? PT2 : PT1;
      exp_d[b] = aes_enc(pt, K1);
      send_block(pt, 0);
      iss[b] = last_edge;
    end
    wait_strobes(8, 100);
    check_val("s_count", q_data.size(), 8);
    for (int b = 0; b < 8; b++) begin
      if (q_data.size() > b) begin
        check_val($sformatf("s_data%0d", b), q_data[b], exp_d[b]);
        check_val($sformatf("s_lat%0d", b), q_edge[b], iss[b] + 23);
      end
    end
    check_val("s_peak", peak, 6);
    check_val("s_infl0", inflight, 0);

    // key race: load K2 on block A's fourth-word edge
    clear_q();
    pt = PT2;
    for (int i = 0; i < 3; i++) send_word(pt[127-32*i -: 32], 0);
    key_in = K2;
    key_load = 1'b1;
    send_word(pt[31:0], 0);
    key_load = 1'b0;
    iss[0] = last_edge;
    check_val("k_keyA", key, K1);
    send_block(PT1, 0);
    iss[1] = last_edge;
    check_val("k_keyB", key, K2);
    wait_strobes(2, 60);
    check_val("k_count", q_data.size(), 2);
    if (q_data.size() > 1) begin
      check_val("k_dataA", q_data[0], aes_enc(PT2, K1));
      check_val("k_dataB", q_data[1], aes_enc(PT1, K2));
      check_val("k_latB", q_edge[1], iss[1] + 23);
    end

    // abort coinciding with a valid third word
    clear_q();
    pt = PT2;
    send_word(pt[127:96], 0);
    send_word(pt[95:64], 0);
    abort = 1'b1;
    send_word(pt[63:32], 0);
    abort = 1'b0;
    send_block(PT1, 0);
    iss[0] = last_edge;
    wait_strobes(2, 60);
    check_val("a_count", q_data.size(), 1);
    if (q_data.size() > 0) begin
      check_val("a_data", q_data[0], aes_enc(PT1, K2));
      check_val("a_lat", q_edge[0], iss[0] + 23);
    end

    // reset mid-flight
    clear_q();
    send_block(PT1, 0);
    send_block(PT2, 0);
    send_block(PT1, 0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("m_ready", din_ready, 0);
    check_val("m_state", state, 0);
    check_val("m_key", key, 0);
    check_val("m_dout", dout, 0);
    check_val("m_dvalid", dout_valid, 0);
    check_val("m_infl", inflight, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_val("m_nostrobe", q_data.size(), 0);
    send_block(PT2, 0);
    iss[0] = last_edge;
    check_val("m_keyzero", key, 0);
    wait_strobes(1, 60);
    check_val("m_count", q_data.size(), 1);
    if (q_data.size() > 0) begin
      check_val("m_data", q_data[0], aes_enc(PT2, 128'h0));
      check_val("m_lat", q_edge[0], iss[0] + 23);
    end

    // gapped input
    load_key(K1);
    clear_q();
    gaps[0] = 0; gaps[1] = 3; gaps[2] = 1; gaps[3] = 2;
    pt = PT1;
    for (int i = 0; i < 4; i++) send_word(pt[127-32*i -: 32], gaps[i]);
    iss[0] = last_edge;
    wait_strobes(1, 60);
    check_val("g_count", q_data.size(), 1);
    if (q_data.size() > 0) begin
      check_val("g_data", q_data[0], CT11);
      check_val("g_lat", q_edge[0], iss[0] + 23);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
